sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised, pipelined sprite/background compositor for the VGA game display. It replaces the fixed frog-plus-three-cars colour path with N_SPR independent sprite channels, each with enable, horizontal mirror and transparency. Pixel output is aligned to the 1-cycle sprite ROM read latency, and per-frame collision flags between channel 0 (player) and every other channel are latched. It sits between the VGA timing counters, the sprite/tile ROMs and the 9-bit VGA pin mapping.

## Interface
- N_SPR, 8: sprite channels; channel 0 is the player and has the highest priority.
- SPR_W, 32: sprite width in pixels, shared by all channels.
- SPR_H, 32: sprite height in pixels.
- ADDR_W, 11: sprite ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H.
- COLOR_W, 9: pixel width {B[2:0],G[2:0],R[2:0]}.
- TRANSPARENT, 9'h000: colour key treated as see-through.
- H_DISPLAY, 640 / V_DISPLAY, 480: visible area.
- CLK  in  1  pixel clock.
- RST_N  in  1  asynchronous, active-low reset.
- h_count, v_count  in  10 each  current pixel coordinates.
- spr_x, spr_y  in  N_SPR*10 each  top-left corner per channel; channel i is [10i+9:10i].
- spr_en  in  N_SPR  channel enable.
- spr_mirror  in  N_SPR  horizontal flip per channel.
- spr_addr  out  N_SPR*ADDR_W  registered ROM address per channel.
- spr_data  in  N_SPR*COLOR_W  ROM data; valid one cycle after spr_addr.
- bg_data  in  COLOR_W  background tile pixel; must arrive with the same alignment as spr_data.
- rgb  out  COLOR_W  composited pixel.
- collision  out  N_SPR  per-frame hit flags; bit 0 is always 0.
- frame_done  out  1  one-cycle pulse when collision updates.

## Operation
- Stage A (edge k): per channel, compute in_box = spr_en[i] && h >= x && h < x+SPR_W && v >= y && v < y+SPR_H.
  - Comparisons use 11-bit sums so that x+SPR_W never wraps.
  - rel_x = h-x and rel_y = v-y.
  - spr_addr = rel_y*SPR_W + (spr_mirror ? SPR_W-1-rel_x : rel_x). Mirror maps rel_x=0 to SPR_W-1 exactly.
  - When in_box is 0, spr_addr is 0.
  - Also register visible = (h<H_DISPLAY && v<V_DISPLAY), and h/v for collision timing.
- Stage B (edge k+1): the ROM captures the address. in_box, visible and the coordinates are delayed by one register.
- Stage C (edge k+2): opaque[i] = in_box_d[i] && spr_data[i] != TRANSPARENT.
  - If visible_d is 0, rgb = 0.
  - Otherwise rgb = spr_data of the lowest-index opaque channel; if no channel is opaque, rgb = bg_data.
- Collision accumulator: at stage C, if visible_d && opaque[0], then hit_acc[i] |= opaque[i] for each i >= 1.
- Frame latch: when the stage-C delayed coordinates equal (h=0, v=V_DISPLAY):
  - collision <= hit_acc;
  - hit_acc <= 0;
  - frame_done <= 1 for that cycle only.
  - Accumulation never coincides with this cycle, because the pixel is not visible.
- spr_x, spr_y, spr_en and spr_mirror are sampled every pixel. Changes apply from the next sampled pixel. The game logic updates them only during vertical blanking.

## Timing
- Latency: h_count/v_count sampled at edge k produce rgb after edge k+2 (2 cycles). The top level delays hsync/vsync by 2 cycles to match.
- spr_addr is registered at edge k. Data is valid on spr_data after edge k+1 and consumed at edge k+2.
- Throughput: one pixel per clock, no stalls.
- Reset (asynchronous assert, synchronous-safe release) clears rgb, spr_addr, collision, frame_done, hit_acc and all pipeline flags to 0. The first valid rgb is the third edge after release.
- Reset mid-frame discards the accumulator. collision stays 0 until the next frame latch.
- Boundary cases:
  - x = 1023 - SPR_W + 5: the box is clipped at h = 1023, with no wrap to h = 0.
  - Pixels with h >= H_DISPLAY output 0 even if a sprite covers them.

## Test plan
- Channel 0 at (100,100), enabled, ROM pixel (0,0)=9'h1C7 → spr_addr0=0 after edge k; rgb=9'h1C7 two cycles after h=100,v=100 is sampled; h=99 gives bg_data.
- Mirror: channel 1, SPR_W=32, h=x+0 → spr_addr1=31; h=x+31 → spr_addr1=0; row 2 adds 64.
- Priority/transparency: channels 0 and 3 overlap. Channel 0 data=9'h038 gives 9'h038. Channel 0 data=TRANSPARENT with channel 3 data=9'h007 gives 9'h007. Both transparent gives bg_data.
- Collision: the player opaque box overlaps channel 2 opaque for one pixel in frame N → at (0,480) collision=8'b0000_0100 and frame_done pulses 1 cycle. With no overlap in frame N+1, collision=0 at the next latch.
- Disabled/edge: spr_en[4]=0 overlapping the player gives no rgb contribution and no collision bit 4. Channel at x=1020 gives no artefact at h=0..3.
- Reset mid-frame with RST_N low for 3 cycles → rgb, collision, frame_done and spr_addr read 0 immediately; the next frame_done reports only hits after release.

Source files
------------

// File: rtl/sprite_compositor_if.sv
// Pixel-side bus of the sprite compositor: VGA coordinates, per-channel sprite
// controls, sprite ROM address/data, background pixel and composited outputs.
interface sprite_compositor_if #(
  parameter int unsigned N_SPR   = 8,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned COLOR_W = 9
);
  logic [9:0]               h_count;
  logic [9:0]               v_count;
  logic [N_SPR*10-1:0]      spr_x;
  logic [N_SPR*10-1:0]      spr_y;
  logic [N_SPR-1:0]         spr_en;
  logic [N_SPR-1:0]         spr_mirror;
  logic [N_SPR*ADDR_W-1:0]  spr_addr;
  logic [N_SPR*COLOR_W-1:0] spr_data;
  logic [COLOR_W-1:0]       bg_data;
  logic [COLOR_W-1:0]       rgb;
  logic [N_SPR-1:0]         collision;
  logic                     frame_done;

  modport master (
    output h_count, v_count, spr_x, spr_y, spr_en, spr_mirror, spr_data, bg_data,
    input  spr_addr, rgb, collision, frame_done
  );

  modport slave (
    input  h_count, v_count, spr_x, spr_y, spr_en, spr_mirror, spr_data, bg_data,
    output spr_addr, rgb, collision, frame_done
  );
endinterface

// File: rtl/sprite_compositor.sv
// Three-stage sprite/background compositor: box test and ROM addressing, ROM
// latency alignment, then priority/transparency mux with per-frame collision latch.
module sprite_compositor #(
  parameter int unsigned         N_SPR       = 8,
  parameter int unsigned         SPR_W       = 32,
  parameter int unsigned         SPR_H       = 32,
  parameter int unsigned         ADDR_W      = 11,
  parameter int unsigned         COLOR_W     = 9,
  parameter logic [COLOR_W-1:0]  TRANSPARENT = '0,
  parameter int unsigned         H_DISPLAY   = 640,
  parameter int unsigned         V_DISPLAY   = 480
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  sprite_compositor_if.slave bus
);
  localparam int unsigned CRD_W = 10;
  localparam int unsigned SUM_W = 11;

  logic [SUM_W-1:0]   w_h;
  logic [SUM_W-1:0]   w_v;
  logic               w_visible;
  logic [N_SPR-1:0]   w_in_box;
  logic [ADDR_W-1:0]  w_addr [N_SPR];
  logic [COLOR_W-1:0] w_data [N_SPR];
  logic [N_SPR-1:0]   w_opaque;
  logic [COLOR_W-1:0] w_pix;
  logic               w_latch;

  logic [N_SPR-1:0]   r_in_box_a;
  logic [ADDR_W-1:0]  r_addr [N_SPR];
  logic               r_vis_a;
  logic [CRD_W-1:0]   r_h_a;
  logic [CRD_W-1:0]   r_v_a;
  logic [N_SPR-1:0]   r_in_box_b;
  logic               r_vis_b;
  logic [CRD_W-1:0]   r_h_b;
  logic [CRD_W-1:0]   r_v_b;
  logic [COLOR_W-1:0] r_rgb;
  logic [N_SPR-1:0]   r_hit_acc;
  logic [N_SPR-1:0]   r_collision;
  logic               r_frame_done;

  // 11-bit coordinates keep x+SPR_W from wrapping at the right edge
  assign w_h       = {1'b0, bus.h_count};
  assign w_v       = {1'b0, bus.v_count};
  assign w_visible = (bus.h_count < CRD_W'(H_DISPLAY)) && (bus.v_count < CRD_W'(V_DISPLAY));

  for (genvar g = 0; g < N_SPR; g++) begin : g_ch
    logic [SUM_W-1:0]  w_x;
    logic [SUM_W-1:0]  w_y;
    logic [SUM_W-1:0]  w_rel_x;
    logic [SUM_W-1:0]  w_rel_y;
    logic [ADDR_W-1:0] w_col;

    assign w_x         = {1'b0, bus.spr_x[CRD_W*g +: CRD_W]};
    assign w_y         = {1'b0, bus.spr_y[CRD_W*g +: CRD_W]};
    assign w_in_box[g] = bus.spr_en[g]
                         && (w_h >= w_x) && (w_h < w_x + SUM_W'(SPR_W))
                         && (w_v >= w_y) && (w_v < w_y + SUM_W'(SPR_H));
    assign w_rel_x     = w_h - w_x;
    assign w_rel_y     = w_v - w_y;
    assign w_col       = bus.spr_mirror[g] ? ADDR_W'(SPR_W - 1) - ADDR_W'(w_rel_x)
                                           : ADDR_W'(w_rel_x);
    assign w_addr[g]   = w_in_box[g] ? ADDR_W'(32'(w_rel_y) * SPR_W) + w_col : '0;
    assign w_data[g]   = bus.spr_data[COLOR_W*g +: COLOR_W];
    assign w_opaque[g] = r_in_box_b[g] && (w_data[g] != TRANSPARENT);
    assign bus.spr_addr[ADDR_W*g +: ADDR_W] = r_addr[g];
  end

  // Lowest-index opaque channel wins; background shows through otherwise
  always_comb begin
    w_pix = bus.bg_data;
    for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
      if (w_opaque[i]) w_pix = w_data[i];
    end
  end

  assign w_latch = (r_h_b == '0) && (r_v_b == CRD_W'(V_DISPLAY));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_box_a   <= '0;
      r_vis_a      <= 1'b0;
      r_h_a        <= '0;
      r_v_a        <= '0;
      r_in_box_b   <= '0;
      r_vis_b      <= 1'b0;
      r_h_b        <= '0;
      r_v_b        <= '0;
      r_rgb        <= '0;
      r_hit_acc    <= '0;
      r_collision  <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < int'(N_SPR); i++) r_addr[i] <= '0;
    end else begin
      r_in_box_a <= w_in_box;
      r_vis_a    <= w_visible;
      r_h_a      <= bus.h_count;
      r_v_a      <= bus.v_count;
      for (int i = 0; i < int'(N_SPR); i++) r_addr[i] <= w_addr[i];

      r_in_box_b <= r_in_box_a;
      r_vis_b    <= r_vis_a;
      r_h_b      <= r_h_a;
      r_v_b      <= r_v_a;

      r_rgb        <= r_vis_b ? w_pix : '0;
      r_frame_done <= w_latch;
      // Latch pixel is never visible, so latch and accumulate are exclusive
      if (w_latch) begin
        r_collision <= r_hit_acc;
        r_hit_acc   <= '0;
      end else if (r_vis_b && w_opaque[0]) begin
        r_hit_acc <= r_hit_acc | (w_opaque & ~N_SPR'(1));
      end
    end
  end

  assign bus.rgb        = r_rgb;
  assign bus.collision  = r_collision;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized bench for sprite_compositor: every pixel is predicted from the
// sprite rules by a behavioural model and compared when it leaves the pipeline.
module tb_sprite_compositor;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int AW = 11;
  localparam int CW = 9;
  localparam int HD = 640;
  localparam int VD = 480;

  typedef struct packed {
    logic [CW-1:0]   rgb;
    logic [N-1:0]    hits;
    logic            latch;
    logic [N*AW-1:0] addr;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_compositor_if #(.N_SPR(N), .ADDR_W(AW), .COLOR_W(CW)) bus ();

  sprite_compositor #(
    .N_SPR(N), .SPR_W(W), .SPR_H(H), .ADDR_W(AW), .COLOR_W(CW),
    .TRANSPARENT(9'h000), .H_DISPLAY(HD), .V_DISPLAY(VD)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  logic [CW-1:0] rom [N][W*H];
  logic [9:0]    cx [N];
  logic [9:0]    cy [N];
  logic [N-1:0]  cen;
  logic [N-1:0]  cmir;
  logic [9:0]    ph;
  logic [9:0]    pv;
  ent_t          q[$];
  logic [N-1:0]  acc;
  logic [N-1:0]  exp_coll;
  logic          exp_fd;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [CW-1:0] bgf(int h, int v);
    return CW'(h * 7 + v * 13 + 5);
  endfunction

  // Sprite ROMs and background tile ROM, one cycle of read latency
  always @(posedge clk) begin
    ph <= bus.h_count;
    pv <= bus.v_count;
    bus.bg_data <= bgf(int'(ph), int'(pv));
    for (int i = 0; i < N; i++)
      bus.spr_data[CW*i +: CW] <= rom[i][bus.spr_addr[AW*i +: AW]];
  end

  function automatic int maddr(int i, int h, int v);
    int rx;
    int ry;
    if (!cen[i]) return -1;
    rx = h - int'(cx[i]);
    ry = v - int'(cy[i]);
    if (rx < 0 || rx >= W || ry < 0 || ry >= H) return -1;
    if (cmir[i]) rx = W - 1 - rx;
    return ry * W + rx;
  endfunction

  function automatic ent_t model(int h, int v);
    ent_t         e;
    logic [N-1:0] op;
    bit           vis;
    bit           found;
    int           a;
    e     = '0;
    op    = '0;
    found = 0;
    vis   = (h < HD) && (v < VD);
    for (int i = 0; i < N; i++) begin
      a = maddr(i, h, v);
      if (a >= 0) begin
        e.addr[AW*i +: AW] = AW'(a);
        if (rom[i][a] != 9'h000) begin
          op[i] = 1'b1;
          if (!found) begin
            found = 1;
            e.rgb = rom[i][a];
          end
        end
      end
    end
    if (!found) e.rgb = bgf(h, v);
    if (!vis) e.rgb = '0;
    if (vis && op[0]) e.hits = op & ~N'(1);
    e.latch = (h == 0) && (v == VD);
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int h, input int v);
    ent_t e;
    @(negedge clk);
    if (q.size() >= 1) check("spr_addr", bus.spr_addr, q[$].addr);
    if (q.size() >= 3) begin
      e = q.pop_front();
      if (e.latch) begin
        exp_coll = acc;
        acc      = '0;
        exp_fd   = 1'b1;
      end else begin
        acc    = acc | e.hits;
        exp_fd = 1'b0;
      end
      check("rgb", bus.rgb, e.rgb);
      check("collision", bus.collision, exp_coll);
      check("frame_done", bus.frame_done, exp_fd);
    end
    bus.h_count = 10'(h);
    bus.v_count = 10'(v);
    for (int i = 0; i < N; i++) begin
      bus.spr_x[10*i +: 10] = cx[i];
      bus.spr_y[10*i +: 10] = cy[i];
    end
    bus.spr_en     = cen;
    bus.spr_mirror = cmir;
    q.push_back(model(h, v));
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < W*H; j++)
        rom[i][j] = ($urandom_range(0, 3) == 0) ? 9'h000 : CW'($urandom);
  endtask

  task automatic do_reset(input bit refill);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.h_count = 10'd1000;
    bus.v_count = 10'd1000;
    #1;
    check("rst_rgb", bus.rgb, 0);
    check("rst_collision", bus.collision, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_spr_addr", bus.spr_addr, 0);
    if (refill) fill_random();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    acc      = '0;
    exp_coll = '0;
    exp_fd   = 1'b0;
  endtask

  function automatic int clampi(int x, int lo, int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  initial begin
    ent_t m;
    int   mode;
    int   k;
    acc      = '0;
    exp_coll = '0;
    exp_fd   = 1'b0;
    bus.h_count = 10'd1000;
    bus.v_count = 10'd1000;
    bus.spr_x = '0;
    bus.spr_y = '0;
    bus.spr_en = '0;
    bus.spr_mirror = '0;

    // Directed contents: solid sprites with a few transparent holes
    fill_random();
    for (int j = 0; j < W*H; j++) begin
      rom[0][j] = 9'h038;
      rom[2][j] = 9'h0AA;
      rom[3][j] = 9'h007;
      rom[4][j] = 9'h1FF;
    end
    rom[0][0]          = 9'h1C7;
    rom[0][20]         = 9'h000;
    rom[0][21]         = 9'h000;
    rom[3][11]         = 9'h000;
    rom[3][31*32 + 21] = 9'h000;
    cx[0] = 10'd100;  cy[0] = 10'd100;
    cx[1] = 10'd300;  cy[1] = 10'd300;
    cx[2] = 10'd131;  cy[2] = 10'd131;
    cx[3] = 10'd110;  cy[3] = 10'd100;
    cx[4] = 10'd100;  cy[4] = 10'd100;
    cx[5] = 10'd1020; cy[5] = 10'd100;
    cx[6] = 10'd996;  cy[6] = 10'd200;
    cx[7] = 10'd0;    cy[7] = 10'd0;
    cen  = 8'b0110_1111;
    cmir = 8'b0000_0010;

    repeat (3) @(negedge clk);
    check("init_rgb", bus.rgb, 0);
    check("init_collision", bus.collision, 0);
    check("init_frame_done", bus.frame_done, 0);
    check("init_spr_addr", bus.spr_addr, 0);
    rst_n = 1'b1;

    // Hand-computed pins on the model
    m = model(100, 100);
    check("pin_player_rgb", m.rgb, 9'h1C7);
    check("pin_player_addr", m.addr[0 +: AW], 0);
    check("pin_bg_left", model(99, 100).rgb, 9'h1CE);
    check("pin_prio_ch0", model(110, 100).rgb, 9'h038);
    check("pin_transp_ch3", model(120, 100).rgb, 9'h007);
    check("pin_both_transp", model(121, 100).rgb, 9'h068);
    check("pin_mirror_x0", model(300, 300).addr[AW +: AW], 31);
    check("pin_mirror_x31", model(331, 300).addr[AW +: AW], 0);
    check("pin_mirror_row2", model(300, 302).addr[AW +: AW], 95);
    check("pin_hit_ch2", model(131, 131).hits, 8'h04);
    check("pin_offscreen", model(1021, 100).rgb, 0);

    step(100, 100); step(99, 100); step(110, 100); step(120, 100); step(121, 100);
    step(300, 300); step(331, 300); step(300, 302);
    for (int h = 1020; h < 1024; h++) step(h, 100);
    for (int h = 0; h < 4; h++) step(h, 100);
    step(996, 200); step(1023, 200); step(0, 200); step(1, 200); step(700, 120);

    // Frame N: one-pixel player/ch2 overlap plus disabled ch4 under the player
    step(0, VD);
    step(131, 131);
    for (int h = 100; h < 106; h++) step(h, 105);
    step(0, VD);
    repeat (3) step(1000, 1000);
    check("coll_frame_n", bus.collision, 8'h04);

    // Frame N+1: no overlaps
    step(100, 100); step(99, 100); step(300, 300); step(102, 110);
    step(0, VD);
    repeat (3) step(1000, 1000);
    check("coll_frame_n1", bus.collision, 8'h00);

    do_reset(1'b1);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        cen[i]  = ($urandom_range(0, 3) != 0);
        cmir[i] = 1'($urandom);
      end
      cx[0] = 10'($urandom_range(0, 620));
      cy[0] = 10'($urandom_range(0, 460));
      for (int i = 1; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       cx[i] = 10'd1020;
          1:       cx[i] = 10'd996;
          2, 3:    cx[i] = 10'(clampi(int'(cx[0]) + int'($urandom_range(0, 48)) - 24, 0, 1023));
          default: cx[i] = 10'($urandom_range(0, 1000));
        endcase
        if ($urandom_range(0, 1) == 0)
          cy[i] = 10'(clampi(int'(cy[0]) + int'($urandom_range(0, 48)) - 24, 0, 500));
        else
          cy[i] = 10'($urandom_range(0, 500));
      end
      for (int s = 0; s < 300; s++) begin
        if (r == 5 && s == 150) do_reset(1'b0);
        mode = $urandom_range(0, 19);
        if (mode == 0) begin
          step(0, VD);
        end else if (mode == 1) begin
          step($urandom_range(0, 1023), $urandom_range(0, 524));
        end else begin
          k = (mode < 9) ? 0 : $urandom_range(0, N - 1);
          step(clampi(int'(cx[k]) + int'($urandom_range(0, W + 3)) - 2, 0, 1023),
               clampi(int'(cy[k]) + int'($urandom_range(0, H + 3)) - 2, 0, 1023));
        end
      end
    end
    repeat (3) step(1000, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
